// File: rtl/uart8_receiver_if.sv
// Signal bundle between the 8-N-1 UART receiver and its consumer.
// The receiver takes the slave side; whoever drives the line and enable is the master.
interface uart8_receiver_if;
    logic       en;
    logic       rx;
    logic [7:0] out;
    logic       busy;
    logic       done;
    logic       err;

    modport master (output en, rx, input out, busy, done, err);
    modport slave  (input en, rx, output out, busy, done, err);
endinterface

// File: rtl/uart8_receiver.sv
// 8-N-1 UART receiver with 16x oversampling derived directly from the board clock.
// Samples mid-bit, shifts LSB-first, and flags framing errors on a zero stop bit.
module uart8_receiver #(
    parameter int CLOCK_RATE = 12_000_000,
    parameter int BAUD_RATE  = 9600
) (
    input  logic              clk,
    input  logic              rst,
    uart8_receiver_if.slave   bus
);
    localparam int DIV = CLOCK_RATE / (BAUD_RATE * 16);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    if (DIV < 1) begin : gDivCheck
        $error("uart8_receiver: CLOCK_RATE too low for 16x oversampling of BAUD_RATE");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rxState_t;

    rxState_t      state_r, nextState_s;
    logic          rxMeta_r, rxSync_r, rxPrev_r;
    logic [DW-1:0] divCnt_r;
    logic [3:0]    tcnt_r;
    logic [2:0]    bcnt_r;
    logic [7:0]    shreg_r, out_r;
    logic          busy_r, done_r, err_r;
    logic          tick_s, startEdge_s, shift_s, frameOk_s, frameBad_s;

    assign tick_s = (divCnt_r == DIV_LAST);

    // Next-state decode; en low drops any frame in progress without a strobe.
    always_comb begin
        nextState_s = state_r;
        startEdge_s = 1'b0;
        shift_s     = 1'b0;
        frameOk_s   = 1'b0;
        frameBad_s  = 1'b0;
        if (!bus.en) begin
            nextState_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (rxPrev_r && !rxSync_r) begin
                        nextState_s = START;
                        startEdge_s = 1'b1;
                    end else begin
                        nextState_s = IDLE;
                    end
                end
                START: begin
                    if (tick_s && (tcnt_r == 4'd7)) begin
                        nextState_s = rxSync_r ? IDLE : DATA;
                    end else begin
                        nextState_s = START;
                    end
                end
                DATA: begin
                    if (tick_s && (tcnt_r == 4'd15)) begin
                        shift_s     = 1'b1;
                        nextState_s = (bcnt_r == 3'd7) ? STOP : DATA;
                    end else begin
                        nextState_s = DATA;
                    end
                end
                STOP: begin
                    if (tick_s && (tcnt_r == 4'd15)) begin
                        nextState_s = IDLE;
                        frameOk_s   = rxSync_r;
                        frameBad_s  = !rxSync_r;
                    end else begin
                        nextState_s = STOP;
                    end
                end
                default: nextState_s = IDLE;
            endcase
        end
    end

    // State, synchronizer, strobes and the received byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            rxMeta_r <= 1'b1;
            rxSync_r <= 1'b1;
            rxPrev_r <= 1'b1;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            out_r    <= 8'h00;
        end else begin
            state_r  <= nextState_s;
            rxMeta_r <= bus.rx;
            rxSync_r <= rxMeta_r;
            rxPrev_r <= rxSync_r;
            busy_r   <= (nextState_s != IDLE);
            done_r   <= frameOk_s;
            err_r    <= frameBad_s;
            if (frameOk_s) begin
                out_r <= shreg_r;
            end
        end
    end

    // Oversampling divider and bit timing; the start edge re-phases everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            divCnt_r <= '0;
            tcnt_r   <= 4'd0;
            bcnt_r   <= 3'd0;
            shreg_r  <= 8'h00;
        end else begin
            if (startEdge_s || tick_s) begin
                divCnt_r <= '0;
            end else begin
                divCnt_r <= divCnt_r + DW'(1);
            end

            if (startEdge_s) begin
                tcnt_r <= 4'd0;
            end else if (tick_s) begin
                // Leaving START at the half-bit point restarts the 16-tick bit frame.
                tcnt_r <= ((state_r == START) && (tcnt_r == 4'd7)) ? 4'd0 : tcnt_r + 4'd1;
            end

            if (startEdge_s) begin
                bcnt_r <= 3'd0;
            end else if (shift_s) begin
                bcnt_r <= bcnt_r + 3'd1;
            end

            if (shift_s) begin
                shreg_r <= {rxSync_r, shreg_r[7:1]};
            end
        end
    end

    assign bus.out  = out_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.err  = err_r;
endmodule

// File: doc/uart8_receiver.md
# uart8_receiver

8-N-1 UART receiver: samples the asynchronous serial line `rx` at 16x the baud rate, validates the start bit, shifts in 8 data bits LSB-first, checks the stop bit and presents the byte with a one-cycle `done` strobe. It is the receive-side counterpart of the `Uart8` transmit path and runs directly on the board clock. The internal oversampling divider replaces `BaudRateGenerator`, so the block has one clock domain and no clock-enable inputs from outside.

## Interface
- `CLOCK_RATE`, 12_000_000, board clock frequency in Hz
- `BAUD_RATE`, 9600, line rate in bits/s
- `DIV` (localparam), CLOCK_RATE/(BAUD_RATE*16) truncated; must be >= 1 (elaboration error otherwise)

- `clk`  input  1  board clock; all logic on rising edge
- `rst`  input  1  synchronous, active-high reset
- `en`  input  1  receiver enable; low forces IDLE
- `rx`  input  1  asynchronous serial line, idle high
- `out`  output  8  last correctly framed byte
- `busy`  output  1  high while a frame is in progress (state != IDLE)
- `done`  output  1  one-cycle strobe: `out` just updated
- `err`  output  1  one-cycle strobe: framing error (stop bit sampled 0)

## Operation
- `rx` passes through a 2-flop synchronizer (both flops reset to 1); `rx_s` is the second flop; `rx_p` holds the previous `rx_s`.
- Tick divider: counts 0..DIV-1, emits `tick` when it wraps; cleared to 0 on start-edge detection so ticks are phase-locked to the edge.
- Tick counter `tcnt` (4 bits) counts ticks within a bit; bit counter `bcnt` (3 bits) counts data bits.
- States:
  - IDLE: when `en` and `rx_p`=1, `rx_s`=0 (falling edge, cycle E) -> START; clear divider, `tcnt`, `bcnt`.
  - START: on the 8th tick (mid start bit) sample `rx_s`: 0 -> DATA, `tcnt` cleared; 1 -> IDLE (glitch, no strobe).
  - DATA: on every 16th tick sample `rx_s`, shift into `shreg` (`shreg <= {rx_s, shreg[7:1]}`); after bit 7 (`bcnt`=7) -> STOP.
  - STOP: on the 16th tick sample `rx_s`: 1 -> `out <= shreg`, `done`=1; 0 -> `err`=1, `out` unchanged. Either way -> IDLE.
- From IDLE a new start requires a fresh 1->0 edge, so a held-low line (break) after a framing error does not retrigger.
- `en` low: immediate return to IDLE from any state, no strobe; `out` retained.
- `done` and `err` are never high together.

## Timing
- Reset values: `out`=8'h00, `done`=0, `err`=0, `busy`=0, state IDLE, synchronizer/`rx_p`=1, counters 0.
- `rst` mid-frame: abandons the frame on the next edge; no strobe; `out` cleared to 0.
- Edge at `rx` pin to detection cycle E: 2-3 clocks (synchronizer).
- Tick k after detection falls on the edge at E + k*DIV.
- Start sample: tick 8. Data bit i (0..7): tick 8+16(i+1). Stop sample: tick 152.
- `done`/`err` high for exactly the cycle following the stop-sample edge, i.e. visible in cycle E + 152*DIV + 1.
- `busy` rises in cycle E+1; falls in the same cycle `done`/`err` rises (or the cycle after the start sample on a glitch).
- Back-to-back frames: IDLE is reached at mid-stop bit, so the next start edge half a bit later is caught.
- Tolerates combined baud mismatch up to about +/-4% (sampling at mid-bit, 1/16-bit quantization).

## Test plan
Bench parameters: CLOCK_RATE=3_200_000, BAUD_RATE=100_000 (DIV=2, 32 clocks/bit).
- Single frame 0xA5 (start, 1,0,1,0,0,1,0,1 LSB-first, stop 1) -> `out`=0xA5, `done` high 1 cycle at E+305, `err`=0, `busy` high from E+1 to E+305.
- Back-to-back 0x00 then 0xFF, one stop bit each, no idle gap -> two `done` pulses 320 clocks apart, `out`=0x00 then 0xFF.
- Glitch: `rx` low for 8 clocks then high -> `busy` pulses, returns 0 after start sample; no `done`/`err`; `out` unchanged.
- Framing error: receive 0x11, then 0x3C with stop bit 0 and line held low 2 bit-times -> `err` 1 cycle, `done`=0, `out` stays 0x11, no retrigger during the hold; then line high and frame 0x5A -> `out`=0x5A, `done`.
- Reset mid-frame: assert `rst` 1 cycle during data bit 4 of 0x81 -> `out`=0, `busy`=0, no strobe; next full frame 0x81 -> `out`=0x81, `done`.
- Enable and baud skew: `en`=0 during a frame -> no strobe, `busy`=0. `en`=1, frame 0x55 sent at +3% and at -3% bit period -> `out`=0x55 both times, `err`=0.
